// File: rtl/kbd_ps2_rx.sv
// PS/2 keyboard receiver: synchronises the pins, deserialises 11-bit frames
// and buffers valid scan codes in a small FIFO read by the MMIO mux.
module kbd_ps2_rx #(
   parameter int KB_W        = 8,
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ps2_clk,
   input  logic            ps2_data,
   input  logic            sig_rd_kb,
   output logic [KB_W-1:0] kb_rdata,
   output logic            kb_ready,
   output logic            kb_overflow,
   output logic            kb_frame_err
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic {S_IDLE, S_RECV} state_t;

   state_t          r_state;
   logic [2:0]      r_clk_sync;
   logic [1:0]      r_dat_sync;
   logic [3:0]      r_bit_cnt;
   logic [KB_W:0]   r_shift;
   logic [TW-1:0]   r_to_cnt;
   logic            r_push;
   logic [KB_W-1:0] r_push_data;
   logic            r_frame_err;

   logic [KB_W-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;
   logic            r_overflow;

   logic w_fe;
   logic w_bit;
   logic w_full;
   logic w_pop;
   logic w_push;

   // Stage 2 is the settled level; stage 3 is its one-cycle-old copy for edge detect.
   assign w_fe  = r_clk_sync[2] & ~r_clk_sync[1];
   assign w_bit = r_dat_sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_sync <= 3'b111;
         r_dat_sync <= 2'b11;
      end else begin
         r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
         r_dat_sync <= {r_dat_sync[0], ps2_data};
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register here samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_to_cnt    <= '0;
         r_push      <= 1'b0;
         r_push_data <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_push      <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_to_cnt <= '0;
               if (w_fe && !w_bit) begin
                  r_state   <= S_RECV;
                  r_bit_cnt <= 4'd1;
               end
            end
            S_RECV: begin
               if (w_fe) begin
                  r_to_cnt <= '0;
                  if (r_bit_cnt == 4'd10) begin
                     r_state   <= S_IDLE;
                     r_bit_cnt <= '0;
                     // Odd parity: data plus parity must hold an odd number of ones.
                     if ((^r_shift) && w_bit) begin
                        r_push      <= 1'b1;
                        r_push_data <= r_shift[KB_W-1:0];
                     end else begin
                        r_frame_err <= 1'b1;
                     end
                  end else begin
                     r_shift   <= {w_bit, r_shift[KB_W:1]};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end else if (r_to_cnt == TO_MAX) begin
                  r_state     <= S_IDLE;
                  r_bit_cnt   <= '0;
                  r_to_cnt    <= '0;
                  r_frame_err <= 1'b1;
               end else begin
                  r_to_cnt <= r_to_cnt + TW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_full = (r_count == FULL_CNT);
   assign w_pop  = sig_rd_kb & (r_count != '0);
   assign w_push = r_push & (~w_full | w_pop);

   // NOTE: the storage array has no reset; an empty FIFO masks its contents,
   // so clearing it would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= r_push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   assign kb_ready     = (r_count != '0);
   assign kb_rdata     = kb_ready ? r_mem[r_rd_ptr] : '0;
   assign kb_overflow  = r_overflow;
   assign kb_frame_err = r_frame_err;

endmodule

// File: tb/tb_kbd_ps2_rx.sv
// Directed bench for kbd_ps2_rx: a frame table plus hand-written sequences for
// latency, FIFO full/overflow, timeout and asynchronous reset.
module tb_kbd_ps2_rx;

   localparam int TIMEOUT_CYC = 4096;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic       sig_rd_kb;
   logic [7:0] kb_rdata;
   logic       kb_ready;
   logic       kb_overflow;
   logic       kb_frame_err;

   int total = 0;
   int bad   = 0;
   int err_cnt = 0;

   kbd_ps2_rx #(.KB_W(8), .FIFO_DEPTH(8), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .sig_rd_kb   (sig_rd_kb),
      .kb_rdata    (kb_rdata),
      .kb_ready    (kb_ready),
      .kb_overflow (kb_overflow),
      .kb_frame_err(kb_frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (kb_frame_err === 1'b1) err_cnt++;

   typedef struct {
      logic [7:0] data;
      logic       bad_par;
      logic       bad_stop;
      logic       exp_ready;
      logic [7:0] exp_rdata;
      int         exp_err;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par,
                                             input logic bad_stop);
      return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
   endfunction

   task automatic half();
      repeat (20) @(negedge clk);
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      half();
      ps2_clk = 1'b0;
      half();
      ps2_clk = 1'b1;
   endtask

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) ps2_bit(f[i]);
   endtask

   task automatic send_frame(input logic [10:0] f);
      send_bits(f, 11);
      ps2_data = 1'b1;
      half();
   endtask

   task automatic pop();
      sig_rd_kb = 1'b1;
      @(negedge clk);
      sig_rd_kb = 1'b0;
   endtask

   initial begin
      logic [10:0] f;
      int e0;
      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; sig_rd_kb = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", kb_ready, 1'b0);
      check("rst_rdata", kb_rdata, 8'h00);
      check("rst_ovf", kb_overflow, 1'b0);
      check("rst_err", kb_frame_err, 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Latency: byte appears on the 4th clk after the last pin falling edge.
      f = mk_frame(8'h1C, 1'b0, 1'b0);
      send_bits(f, 10);
      ps2_data = f[10];
      half();
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      check("lat_early_ready", kb_ready, 1'b0);
      @(negedge clk);
      check("lat_ready", kb_ready, 1'b1);
      check("lat_rdata", kb_rdata, 8'h1C);
      half();
      ps2_clk = 1'b1;
      half();
      check("lat_no_err", err_cnt, 0);
      pop();

      // Two frames, then two pops and one pop on empty.
      send_frame(mk_frame(8'h1C, 1'b0, 1'b0));
      send_frame(mk_frame(8'hF0, 1'b0, 1'b0));
      check("two_head", kb_rdata, 8'h1C);
      pop();
      check("two_rdata", kb_rdata, 8'hF0);
      check("two_ready", kb_ready, 1'b1);
      pop();
      check("two_empty_ready", kb_ready, 1'b0);
      check("two_empty_rdata", kb_rdata, 8'h00);
      pop();
      check("pop_empty_ready", kb_ready, 1'b0);

      vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 0};
      vecs[1] = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1};
      vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 0};
      vecs[3] = '{8'hAA, 1'b0, 1'b1, 1'b0, 8'h00, 1};
      vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 0};
      vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 0};
      vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h00, 1};
      for (int i = 0; i < 7; i++) begin
         e0 = err_cnt;
         send_frame(mk_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop));
         check($sformatf("vec%0d_ready", i), kb_ready, vecs[i].exp_ready);
         check($sformatf("vec%0d_rdata", i), kb_rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err);
         if (vecs[i].exp_ready) pop();
      end

      // A falling edge with data high in IDLE is not a start bit and not an error.
      e0 = err_cnt;
      ps2_bit(1'b1);
      half();
      check("nostart_err", err_cnt - e0, 0);
      check("nostart_ready", kb_ready, 1'b0);
      send_frame(mk_frame(8'h33, 1'b0, 1'b0));
      check("nostart_next", kb_rdata, 8'h33);
      pop();

      // Overflow: nine frames, eight stored in order.
      for (int i = 1; i <= 9; i++) send_frame(mk_frame(8'(i), 1'b0, 1'b0));
      check("ovf_set", kb_overflow, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("ovf_rd%0d", i), kb_rdata, 8'(i));
         pop();
      end
      check("ovf_drained", kb_ready, 1'b0);
      check("ovf_sticky", kb_overflow, 1'b1);

      // Asynchronous reset mid-frame with three entries buffered.
      send_frame(mk_frame(8'h11, 1'b0, 1'b0));
      send_frame(mk_frame(8'h22, 1'b0, 1'b0));
      send_frame(mk_frame(8'h33, 1'b0, 1'b0));
      send_bits(mk_frame(8'h77, 1'b0, 1'b0), 4);
      check("pre_rst_ready", kb_ready, 1'b1);
      #3 rst = 1'b1;
      #1;
      check("arst_ready", kb_ready, 1'b0);
      check("arst_rdata", kb_rdata, 8'h00);
      check("arst_ovf", kb_overflow, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      e0 = err_cnt;
      send_frame(mk_frame(8'h44, 1'b0, 1'b0));
      check("post_rst_rdata", kb_rdata, 8'h44);
      check("post_rst_err", err_cnt - e0, 0);
      pop();

      // Full FIFO: push lands on the same edge as a pop.
      for (int i = 1; i <= 8; i++) send_frame(mk_frame(8'(i), 1'b0, 1'b0));
      f = mk_frame(8'h09, 1'b0, 1'b0);
      send_bits(f, 10);
      ps2_data = f[10];
      half();
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      sig_rd_kb = 1'b1;
      @(negedge clk);
      sig_rd_kb = 1'b0;
      half();
      ps2_clk = 1'b1;
      half();
      check("full_pp_ovf", kb_overflow, 1'b0);
      for (int i = 2; i <= 9; i++) begin
         check($sformatf("full_pp_rd%0d", i), kb_rdata, 8'(i));
         pop();
      end
      check("full_pp_drained", kb_ready, 1'b0);

      // Timeout on a partial frame, then a clean frame.
      e0 = err_cnt;
      send_bits(mk_frame(8'h5A, 1'b0, 1'b0), 5);
      repeat (TIMEOUT_CYC - 100) @(negedge clk);
      check("to_not_yet", err_cnt - e0, 0);
      repeat (200) @(negedge clk);
      check("to_err", err_cnt - e0, 1);
      check("to_ready", kb_ready, 1'b0);
      send_frame(mk_frame(8'h2A, 1'b0, 1'b0));
      check("to_next_ready", kb_ready, 1'b1);
      check("to_next_rdata", kb_rdata, 8'h2A);
      check("to_next_err", err_cnt - e0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
